stimulus_gen: RTL and testbench

Synchronous stimulus source for the simple-gates bench. It drives the 4-bit `sw` vector into the gate DUT and the checker: first an exhaustive sweep, then a repeatable pseudo-random phase, then the terminating vector 4'hF. The checker treats 4'hF as its end-of-test marker, so 4'hF appears exactly once per run, as the last case. `busy`, `done` and `case_cnt` expose progress to the bench top.

---
 rtl/stimulus_gen.sv | 102 ++++++++++
 tb/tb_stimulus_gen.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/stimulus_gen.sv
// stimulus_gen: sweep, then LFSR-random, then terminating 4'hF stimulus for the gate bench
// Ports: clk, rst (sync, active high), start (begins a run from IDLE/DONE),
//        sw (held vector), busy (run in progress), done (run finished),
//        case_cnt (1-based index of the vector on sw, 0 when idle).
module stimulus_gen #(
  parameter int unsigned    NO_OF_CASES = 1234,
  parameter int unsigned    HOLD_CYCLES = 1,
  parameter logic [15:0]    LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  sw,
  output logic        busy,
  output logic        done,
  output logic [15:0] case_cnt
);
  typedef enum logic [2:0] {IDLE, SWEEP, RANDOM, FINAL, DONE} state_t;
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [15:0] LAST_RAND = 16'(NO_OF_CASES - 1);
  localparam logic [15:0] LAST_CASE = 16'(NO_OF_CASES);
  state_t      state_q, state_d;
  logic [3:0]  sw_q, sw_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [15:0] case_cnt_q, case_cnt_d, lfsr_q, lfsr_d, lfsr_nx;
  logic [7:0]  hold_q, hold_d;
  logic        adv;
  logic [3:0]  rnd;
  assign adv     = busy_q && hold_q == HOLD_LAST;
  // Fibonacci taps 16,14,13,11 counted from the output end
  assign lfsr_nx = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  // 4'hF is reserved as the checker's end marker
  assign rnd     = lfsr_nx[3:0] == 4'hF ? 4'hE : lfsr_nx[3:0];
  always_comb begin
    state_d    = state_q;
    sw_d       = sw_q;
    busy_d     = busy_q;
    done_d     = done_q;
    case_cnt_d = adv ? case_cnt_q + 16'd1 : case_cnt_q;
    lfsr_d     = lfsr_q;
    hold_d     = adv ? 8'd0 : busy_q ? hold_q + 8'd1 : hold_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d    = SWEEP;
        sw_d       = 4'h0;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        case_cnt_d = 16'd1;
        lfsr_d     = LFSR_SEED;
        hold_d     = 8'd0;
      end
      SWEEP: if (adv) begin
        if (sw_q == 4'hE) begin
          state_d = RANDOM;
          lfsr_d  = lfsr_nx;
          sw_d    = rnd;
        end else
          sw_d = sw_q + 4'h1;
      end
      RANDOM: if (adv) begin
        if (case_cnt_q == LAST_RAND) begin
          state_d    = FINAL;
          sw_d       = 4'hF;
          case_cnt_d = LAST_CASE;
        end else begin
          lfsr_d = lfsr_nx;
          sw_d   = rnd;
        end
      end
      FINAL: if (adv) begin
        state_d    = DONE;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        case_cnt_d = case_cnt_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sw_q       <= 4'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      case_cnt_q <= 16'd0;
      lfsr_q     <= LFSR_SEED;
      hold_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      sw_q       <= sw_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      case_cnt_q <= case_cnt_d;
      lfsr_q     <= lfsr_d;
      hold_q     <= hold_d;
    end
  end
  assign sw       = sw_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign case_cnt = case_cnt_q;
endmodule

// File: tb/tb_stimulus_gen.sv
// tb_stimulus_gen: directed checks of stimulus_gen traces, hold, restart and reset
module tb_stimulus_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  int   sel = 0;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;
  logic [3:0]  sw_a, sw_b, sw_c, o_sw;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c, o_busy, o_done;
  logic [15:0] cnt_a, cnt_b, cnt_c, o_cnt;
  logic        start_a, start_b, start_c;
  assign start_a = start && sel == 0;
  assign start_b = start && sel == 1;
  assign start_c = start && sel == 2;
  stimulus_gen #(.NO_OF_CASES(20), .HOLD_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .sw(sw_a), .busy(busy_a), .done(done_a), .case_cnt(cnt_a));
  stimulus_gen #(.NO_OF_CASES(20), .HOLD_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .sw(sw_b), .busy(busy_b), .done(done_b), .case_cnt(cnt_b));
  stimulus_gen #(.NO_OF_CASES(300), .HOLD_CYCLES(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .sw(sw_c), .busy(busy_c), .done(done_c), .case_cnt(cnt_c));
  always_comb begin
    o_sw   = sel == 0 ? sw_a   : sel == 1 ? sw_b   : sw_c;
    o_busy = sel == 0 ? busy_a : sel == 1 ? busy_b : busy_c;
    o_done = sel == 0 ? done_a : sel == 1 ? done_b : done_c;
    o_cnt  = sel == 0 ? cnt_a  : sel == 1 ? cnt_b  : cnt_c;
  end
  // First four random vectors from seed 16'hACE1, worked out by hand
  logic [3:0] rnd_tab [4] = '{4'h0, 4'h8, 4'hC, 4'hE};
  task automatic run_trace(input int n, input int h, input int mid_k, input string tag);
    logic [3:0]  e;
    logic [21:0] got, want;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 1; k <= n; k++) begin
      e = k <= 15 ? 4'(k - 1) : k == n ? 4'hF : k <= 19 ? rnd_tab[k - 16] : 4'h0;
      for (int j = 0; j < h; j++) begin
        start = k == mid_k && j == 0;
        got  = {o_sw, o_cnt, o_busy, o_done};
        want = {e, 16'(k), 1'b1, 1'b0};
        checks++;
        if (k > 19 && k < n) begin
          if (o_sw == 4'hF || o_cnt !== 16'(k) || o_busy !== 1'b1 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL %s case %0d cyc %0d: got sw=%h cnt=%0d busy=%b done=%b, want non-F cnt=%0d busy=1 done=0",
                     tag, k, j, o_sw, o_cnt, o_busy, o_done, k);
          end
        end else if (got !== want) begin
          errors++;
          $display("FAIL %s case %0d cyc %0d: got sw=%h cnt=%0d busy=%b done=%b, want sw=%h cnt=%0d busy=1 done=0",
                   tag, k, j, o_sw, o_cnt, o_busy, o_done, e, k);
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    for (int j = 0; j < 2; j++) begin
      checks++;
      if ({o_sw, o_cnt, o_busy, o_done} !== {4'hF, 16'(n), 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL %s done cyc %0d: got sw=%h cnt=%0d busy=%b done=%b, want sw=f cnt=%0d busy=0 done=1",
                 tag, j, o_sw, o_cnt, o_busy, o_done, n);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    start = 1'b1;
    sel = 0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      checks++;
      if ({o_sw, o_cnt, o_busy, o_done} !== 22'd0) begin
        errors++;
        $display("FAIL reset dut%0d: got sw=%h cnt=%0d busy=%b done=%b, want all 0", s, o_sw, o_cnt, o_busy, o_done);
      end
    end
    rst = 1'b0;
    start = 1'b0;
    sel = 0;
    @(negedge clk);
    checks++;
    if ({o_sw, o_cnt, o_busy, o_done} !== 22'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got sw=%h cnt=%0d busy=%b done=%b, want all 0", o_sw, o_cnt, o_busy, o_done);
    end
  endtask
  task automatic test_minimal_run;
    sel = 0;
    run_trace(20, 1, 0, "minimal");
  endtask
  task automatic test_hold;
    sel = 1;
    run_trace(20, 3, 0, "hold3");
  endtask
  task automatic test_restart_ignore;
    sel = 0;
    run_trace(20, 1, 8, "restart");
  endtask
  task automatic test_mid_reset;
    sel = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (16) @(negedge clk);
    checks++;
    if (o_cnt !== 16'd17 || o_sw !== rnd_tab[1]) begin
      errors++;
      $display("FAIL pre_reset: got cnt=%0d sw=%h, want cnt=17 sw=%h", o_cnt, o_sw, rnd_tab[1]);
    end
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    checks++;
    if ({o_sw, o_cnt, o_busy, o_done} !== 22'd0) begin
      errors++;
      $display("FAIL mid_reset: got sw=%h cnt=%0d busy=%b done=%b, want all 0", o_sw, o_cnt, o_busy, o_done);
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++;
    if ({o_sw, o_cnt, o_busy, o_done} !== {4'h0, 16'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL restart_after_reset: got sw=%h cnt=%0d busy=%b done=%b, want sw=0 cnt=1 busy=1 done=0",
               o_sw, o_cnt, o_busy, o_done);
    end
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask
  task automatic test_long_run;
    sel = 2;
    run_trace(300, 1, 0, "long");
  endtask
  initial begin
    test_reset();
    test_minimal_run();
    test_hold();
    test_restart_ignore();
    test_mid_reset();
    test_long_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
